// File: rtl/gpio_pio_ctrl_if.sv
// rtl/gpio_pio_ctrl_if.sv - Avalon-MM slave bus bundle for the GPIO PIO controller
interface gpio_pio_ctrl_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/gpio_pio_ctrl.sv
// rtl/gpio_pio_ctrl.sv - debounced GPIO inputs with edge IRQ and set/clear outputs
// Optional blink prescaler and BLINK register enabled by defining GPIO_BLINK_EN.
module gpio_pio_ctrl #(
    parameter int IN_W         = 8,
    parameter int OUT_W        = 8,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int EDGE_MODE    = 0,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic                 clk,
    input  logic                 rst,
    gpio_pio_ctrl_if.slave       avs,
    output logic                 irq,
    input  logic [IN_W-1:0]      gpio_in,
    output logic [OUT_W-1:0]     gpio_out
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [IN_W-1:0]             sync1, sync2, deb, deb_nxt;
    logic [IN_W-1:0]             edge_cap, edge_set, edge_clr, irq_mask;
    logic [IN_W-1:0][CNT_W-1:0]  cnt, cnt_nxt;
    logic [OUT_W-1:0]            data_out, data_out_nxt;
    logic [IN_W-1:0]             wdata_in;
    logic [OUT_W-1:0]            wdata_out;
    logic [31:0]                 rd_mux;
    logic                        unused_wdata;

    assign wdata_in     = avs.avs_writedata[IN_W-1:0];
    assign wdata_out    = avs.avs_writedata[OUT_W-1:0];
    assign unused_wdata = &{1'b0, avs.avs_writedata};

    // Per-bit debounce: a differing sample must persist DEBOUNCE_CYC cycles to be accepted.
    always_comb begin
        deb_nxt = deb;
        cnt_nxt = cnt;
        for (int i = 0; i < IN_W; i++) begin
            if (sync2[i] == deb[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                deb_nxt[i] = sync2[i];
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
        edge_set = '0;
        case (EDGE_MODE)
            0:       edge_set = deb_nxt & ~deb;
            1:       edge_set = ~deb_nxt & deb;
            default: edge_set = deb_nxt ^ deb;
        endcase
    end

    always_comb begin
        edge_clr     = '0;
        data_out_nxt = data_out;
        if (avs.avs_write) begin
            case (avs.avs_address)
                3'd1:    data_out_nxt = wdata_out;
                3'd3:    edge_clr     = wdata_in;
                3'd4:    data_out_nxt = data_out | wdata_out;
                3'd5:    data_out_nxt = data_out & ~wdata_out;
                default: ;
            endcase
        end
    end

`ifdef GPIO_BLINK_EN
    localparam int PRESC_W = $clog2(BLINK_DIV + 1);

    logic [PRESC_W-1:0] presc;
    logic               phase;
    logic [OUT_W-1:0]   blink;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            phase <= 1'b0;
            blink <= '0;
        end else begin
            if (avs.avs_write && avs.avs_address == 3'd6)
                blink <= wdata_out;
            if (presc == PRESC_W'(BLINK_DIV - 1)) begin
                presc <= '0;
                phase <= ~phase;
            end else begin
                presc <= presc + PRESC_W'(1);
            end
        end
    end

    assign gpio_out = data_out ^ (blink & {OUT_W{phase}});
`else
    assign gpio_out = data_out;
`endif

    // Read mux sees pre-write register values, so a same-cycle write does not leak in.
    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            3'd0:    rd_mux[IN_W-1:0]  = deb;
            3'd1:    rd_mux[OUT_W-1:0] = data_out;
            3'd2:    rd_mux[IN_W-1:0]  = irq_mask;
            3'd3:    rd_mux[IN_W-1:0]  = edge_cap;
`ifdef GPIO_BLINK_EN
            3'd6:    rd_mux[OUT_W-1:0] = blink;
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1                 <= '0;
            sync2                 <= '0;
            deb                   <= '0;
            cnt                   <= '0;
            edge_cap              <= '0;
            irq_mask              <= '0;
            data_out              <= '0;
            irq                   <= 1'b0;
            avs.avs_readdata      <= '0;
            avs.avs_readdatavalid <= 1'b0;
        end else begin
            sync1    <= gpio_in;
            sync2    <= sync1;
            deb      <= deb_nxt;
            cnt      <= cnt_nxt;
            // A new edge wins over a same-cycle clear of that bit.
            edge_cap <= (edge_cap & ~edge_clr) | edge_set;
            if (avs.avs_write && avs.avs_address == 3'd2)
                irq_mask <= wdata_in;
            data_out <= data_out_nxt;
            irq      <= |(edge_cap & irq_mask);
            avs.avs_readdatavalid <= avs.avs_read;
            if (avs.avs_read)
                avs.avs_readdata <= rd_mux;
        end
    end
endmodule
